// File: rtl/muldiv_iter_if.sv
// rtl/muldiv_iter_if.sv - issue/result bundle between the core EX stage and muldiv_iter
//
// Purpose : groups the operation request (start/op/a/b/flush) and the
//           completion signals (busy/done/result) of the iterative
//           multiply/divide unit.
// Signals :
//   start   core -> unit  issue strobe, sampled only while the unit is idle
//   op      core -> unit  RV32M funct3 encoding
//   a, b    core -> unit  rs1 / rs2 operands, sampled with start
//   flush   core -> unit  abort any in-flight operation
//   busy    unit -> core  operation in progress (core stalls ID/EX)
//   done    unit -> core  one-cycle completion pulse
//   result  unit -> core  last completed result, held until the next one
// Modports: master = core side, slave = unit side.

interface muldiv_iter_if #(
    parameter int XLEN = 32
);
    logic            start;
    logic [2:0]      op;
    logic [XLEN-1:0] a;
    logic [XLEN-1:0] b;
    logic            flush;
    logic            busy;
    logic            done;
    logic [XLEN-1:0] result;

    modport master (
        output start, op, a, b, flush,
        input  busy, done, result
    );

    modport slave (
        input  start, op, a, b, flush,
        output busy, done, result
    );
endinterface

// File: rtl/muldiv_iter.sv
// rtl/muldiv_iter.sv - iterative RV32M multiply/divide unit, one bit per cycle
//
// Purpose : shift-add multiplication and restoring division on operand
//           magnitudes, with sign fix-up in a final cycle. Divide-by-zero
//           and signed overflow finish on a one-cycle fast path.
// Ports   :
//   clk     rising-edge clock
//   rst     asynchronous active-low reset
//   bus     muldiv_iter_if slave modport (start/op/a/b/flush in,
//           busy/done/result out)
// Latency : XLEN+2 cycles from the start cycle to done; fast path 1 cycle.

module muldiv_iter #(
    parameter int XLEN  = 32,
    parameter int CNT_W = $clog2(XLEN) + 1
) (
    input  logic         clk,
    input  logic         rst,
    muldiv_iter_if.slave bus
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_CALC = 2'd1,
        S_FIX  = 2'd2
    } state_t;

    localparam logic [2:0] OP_MUL    = 3'b000;
    localparam logic [2:0] OP_MULH   = 3'b001;
    localparam logic [2:0] OP_MULHSU = 3'b010;
    localparam logic [2:0] OP_DIV    = 3'b100;
    localparam logic [2:0] OP_REM    = 3'b110;

    localparam logic [XLEN-1:0] ALL_ONES = {XLEN{1'b1}};
    localparam logic [XLEN-1:0] MOST_NEG = {1'b1, {(XLEN-1){1'b0}}};

    // ------------------------------------------------------------------
    // State
    // ------------------------------------------------------------------
    state_t            state_q,  state_d;
    logic [CNT_W-1:0]  cnt_q,    cnt_d;
    logic [2:0]        op_q,     op_d;
    logic              neg_q,    neg_d;
    // Multiply: full product, multiplier consumed from the low end.
    // Divide  : low half holds dividend, shifting out while quotient
    //           bits shift in.
    logic [2*XLEN-1:0] prod_q,   prod_d;
    // Multiplicand (multiply) or divisor (divide) magnitude.
    logic [XLEN-1:0]   mcand_q,  mcand_d;
    // Partial remainder; always below the divisor so XLEN bits suffice
    // between iterations, the extra bit lives only in the trial value.
    logic [XLEN-1:0]   rem_q,    rem_d;
    logic              busy_q,   busy_d;
    logic              done_q,   done_d;
    logic [XLEN-1:0]   result_q, result_d;

    // ------------------------------------------------------------------
    // Issue-time decode
    // ------------------------------------------------------------------
    logic            is_div_in;
    logic            a_signed, b_signed;
    logic            a_neg, b_neg;
    logic [XLEN-1:0] mag_a, mag_b;
    logic            sign_in;
    logic            b_zero, ovf, fast;
    logic [XLEN-1:0] fast_res;

    assign is_div_in = bus.op[2];
    assign a_signed  = (bus.op == OP_MULH) || (bus.op == OP_MULHSU) ||
                       (bus.op == OP_DIV)  || (bus.op == OP_REM);
    assign b_signed  = (bus.op == OP_MULH) || (bus.op == OP_DIV) ||
                       (bus.op == OP_REM);
    assign a_neg     = a_signed & bus.a[XLEN-1];
    assign b_neg     = b_signed & bus.b[XLEN-1];
    assign mag_a     = a_neg ? (~bus.a + 1'b1) : bus.a;
    assign mag_b     = b_neg ? (~bus.b + 1'b1) : bus.b;

    // Remainder takes the dividend's sign; product and quotient take the
    // XOR of the effective operand signs.
    assign sign_in   = (is_div_in & bus.op[1]) ? a_neg : (a_neg ^ b_neg);

    assign b_zero    = (bus.b == '0);
    assign ovf       = ((bus.op == OP_DIV) || (bus.op == OP_REM)) &&
                       (bus.a == MOST_NEG) && (bus.b == ALL_ONES);
    assign fast      = is_div_in & (b_zero | ovf);

    always_comb begin
        fast_res = '0;
        if (b_zero) begin
            fast_res = bus.op[1] ? bus.a : ALL_ONES;
        end else begin
            fast_res = bus.op[1] ? '0 : bus.a;
        end
    end

    // ------------------------------------------------------------------
    // Iteration datapath
    // ------------------------------------------------------------------
    logic [XLEN:0]     mul_sum;
    logic [2*XLEN-1:0] mul_next;
    logic [XLEN:0]     rem_sh;
    logic [XLEN:0]     trial;
    logic              q_bit;
    logic [XLEN-1:0]   rem_next;
    logic [XLEN-1:0]   dvd_next;

    // The carry out of the add becomes the new product MSB after the shift.
    assign mul_sum  = {1'b0, prod_q[2*XLEN-1:XLEN]} +
                      {1'b0, (prod_q[0] ? mcand_q : {XLEN{1'b0}})};
    assign mul_next = {mul_sum, prod_q[XLEN-1:1]};

    assign rem_sh   = {rem_q, prod_q[XLEN-1]};
    assign trial    = rem_sh - {1'b0, mcand_q};
    assign q_bit    = ~trial[XLEN];
    assign rem_next = q_bit ? trial[XLEN-1:0] : rem_sh[XLEN-1:0];
    assign dvd_next = {prod_q[XLEN-2:0], q_bit};

    // ------------------------------------------------------------------
    // Sign fix-up and result selection
    // ------------------------------------------------------------------
    logic [2*XLEN-1:0] prod_fix;
    logic [XLEN-1:0]   quot_fix;
    logic [XLEN-1:0]   rem_fix;
    logic [XLEN-1:0]   fix_res;

    assign prod_fix = neg_q ? (~prod_q + 1'b1) : prod_q;
    assign quot_fix = neg_q ? (~prod_q[XLEN-1:0] + 1'b1) : prod_q[XLEN-1:0];
    assign rem_fix  = neg_q ? (~rem_q + 1'b1) : rem_q;

    always_comb begin
        fix_res = '0;
        if (!op_q[2]) begin
            fix_res = (op_q == OP_MUL) ? prod_fix[XLEN-1:0]
                                       : prod_fix[2*XLEN-1:XLEN];
        end else begin
            fix_res = op_q[1] ? rem_fix : quot_fix;
        end
    end

    // ------------------------------------------------------------------
    // Next-state logic
    // ------------------------------------------------------------------
    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        op_d     = op_q;
        neg_d    = neg_q;
        prod_d   = prod_q;
        mcand_d  = mcand_q;
        rem_d    = rem_q;
        done_d   = 1'b0;
        result_d = result_q;

        unique case (state_q)
            S_IDLE: begin
                if (bus.start && !bus.flush) begin
                    if (fast) begin
                        result_d = fast_res;
                        done_d   = 1'b1;
                    end else begin
                        op_d    = bus.op;
                        neg_d   = sign_in;
                        cnt_d   = CNT_W'(XLEN);
                        rem_d   = '0;
                        state_d = S_CALC;
                        if (is_div_in) begin
                            prod_d  = {{XLEN{1'b0}}, mag_a};
                            mcand_d = mag_b;
                        end else begin
                            prod_d  = {{XLEN{1'b0}}, mag_b};
                            mcand_d = mag_a;
                        end
                    end
                end
            end

            S_CALC: begin
                cnt_d = cnt_q - 1'b1;
                if (op_q[2]) begin
                    prod_d = {prod_q[2*XLEN-1:XLEN], dvd_next};
                    rem_d  = rem_next;
                end else begin
                    prod_d = mul_next;
                end
                if (cnt_q == CNT_W'(1)) begin
                    state_d = S_FIX;
                end
            end

            S_FIX: begin
                result_d = fix_res;
                done_d   = 1'b1;
                state_d  = S_IDLE;
            end

            default: begin
                state_d = S_IDLE;
            end
        endcase

        // Flush beats everything, including a same-cycle start or a
        // completing FIX: the aborted operation leaves no trace on outputs.
        if (bus.flush) begin
            state_d  = S_IDLE;
            done_d   = 1'b0;
            result_d = result_q;
        end
    end

    // busy is registered from the next state so it rises in the first CALC
    // cycle and falls in the done cycle.
    assign busy_d = (state_d != S_IDLE);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q  <= S_IDLE;
            cnt_q    <= '0;
            op_q     <= '0;
            neg_q    <= 1'b0;
            prod_q   <= '0;
            mcand_q  <= '0;
            rem_q    <= '0;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
            result_q <= '0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            op_q     <= op_d;
            neg_q    <= neg_d;
            prod_q   <= prod_d;
            mcand_q  <= mcand_d;
            rem_q    <= rem_d;
            busy_q   <= busy_d;
            done_q   <= done_d;
            result_q <= result_d;
        end
    end

    assign bus.busy   = busy_q;
    assign bus.done   = done_q;
    assign bus.result = result_q;

endmodule

// File: tb/tb_muldiv_iter.sv
// tb/tb_muldiv_iter.sv - self-checking bench for muldiv_iter at XLEN=32 and XLEN=16

module tb_muldiv_iter;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic rst32;
    logic rst16;

    muldiv_iter_if #(.XLEN(32)) m32 ();
    muldiv_iter_if #(.XLEN(16)) m16 ();

    muldiv_iter #(.XLEN(32)) dut32 (.clk(clk), .rst(rst32), .bus(m32));
    muldiv_iter #(.XLEN(16)) dut16 (.clk(clk), .rst(rst16), .bus(m16));

    logic [63:0] sb_q[$];
    logic [63:0] exp_last;
    int          pass_cnt = 0;
    int          tot_cnt  = 0;
    bit          w16      = 1'b0;

    task automatic check(input string name, input logic [63:0] obs, input logic [63:0] exp);
        tot_cnt++;
        assert (obs === exp) pass_cnt++;
        else $error("FAIL %s: observed 0x%0h expected 0x%0h", name, obs, exp);
    endtask

    function automatic logic get_busy();
        return w16 ? m16.busy : m32.busy;
    endfunction

    function automatic logic get_done();
        return w16 ? m16.done : m32.done;
    endfunction

    function automatic logic [63:0] get_result();
        return w16 ? {48'h0, m16.result} : {32'h0, m32.result};
    endfunction

    task automatic drive(input bit s, input logic [2:0] op, input logic [63:0] a, input logic [63:0] b);
        if (w16) begin
            m16.start = s; m16.op = op; m16.a = a[15:0]; m16.b = b[15:0];
        end else begin
            m32.start = s; m32.op = op; m32.a = a[31:0]; m32.b = b[31:0];
        end
    endtask

    task automatic set_start(input bit s);
        if (w16) m16.start = s;
        else     m32.start = s;
    endtask

    task automatic set_flush(input bit f);
        if (w16) m16.flush = f;
        else     m32.flush = f;
    endtask

    task automatic issue(input logic [2:0] op, input logic [63:0] a, input logic [63:0] b,
                         input logic [63:0] exp);
        drive(1'b1, op, a, b);
        sb_q.push_back(exp);
    endtask

    // Counts cycles after the start edge until done; optionally pokes a
    // second start (DIVU 9/9) at cycle 'poke' while the first is in flight.
    task automatic wait_done(input string name, input int lat, input int poke);
        int          n    = 0;
        int          bcnt = 0;
        bit          got  = 1'b0;
        logic        busy_at_done = 1'b1;
        logic [63:0] exp;
        while (n < 100 && !got) begin
            @(posedge clk); #1;
            n++;
            if (n == 1) set_start(1'b0);
            if (poke != 0 && n == poke)     drive(1'b1, 3'b101, 64'd9, 64'd9);
            if (poke != 0 && n == poke + 1) set_start(1'b0);
            if (get_done()) begin
                got = 1'b1;
                busy_at_done = get_busy();
            end else if (get_busy()) begin
                bcnt++;
            end
        end
        exp = sb_q.pop_front();
        check({name, " done"}, 64'(got), 64'd1);
        check({name, " latency"}, 64'(n), 64'(lat));
        check({name, " busy_cycles"}, 64'(bcnt), 64'(lat - 1));
        check({name, " busy_at_done"}, 64'(busy_at_done), 64'd0);
        check({name, " result"}, get_result(), exp);
        exp_last = exp;
    endtask

    task automatic run(input string name, input logic [2:0] op, input logic [63:0] a,
                       input logic [63:0] b, input logic [63:0] exp, input int lat);
        @(negedge clk);
        issue(op, a, b, exp);
        wait_done(name, lat, 0);
    endtask

    initial begin
        bit seen;
        rst32 = 1'b0;
        rst16 = 1'b0;
        w16 = 1'b1; drive(1'b0, 3'b000, 64'd0, 64'd0); set_flush(1'b0);
        w16 = 1'b0; drive(1'b0, 3'b000, 64'd0, 64'd0); set_flush(1'b0);
        exp_last = 64'd0;

        repeat (2) @(posedge clk);
        #1;
        check("reset busy", 64'(m32.busy), 64'd0);
        check("reset done", 64'(m32.done), 64'd0);
        check("reset result", 64'(m32.result), 64'd0);
        @(negedge clk);
        rst32 = 1'b1;
        rst16 = 1'b1;

        run("mul 7x6", 3'b000, 64'd7, 64'd6, 64'd42, 34);
        @(posedge clk); #1;
        check("done single pulse", 64'(m32.done), 64'd0);

        run("mulh -1x-1",   3'b001, 64'hFFFFFFFF, 64'hFFFFFFFF, 64'h00000000, 34);
        run("mulhsu",       3'b010, 64'hFFFFFFFF, 64'hFFFFFFFF, 64'hFFFFFFFF, 34);
        run("mulhu",        3'b011, 64'hFFFFFFFF, 64'hFFFFFFFF, 64'hFFFFFFFE, 34);
        run("mul wrap",     3'b000, 64'h80000000, 64'd2,        64'h00000000, 34);
        run("mul -3x5",     3'b000, 64'hFFFFFFFD, 64'd5,        64'hFFFFFFF1, 34);
        run("mulh -3x5",    3'b001, 64'hFFFFFFFD, 64'd5,        64'hFFFFFFFF, 34);
        run("div -7/2",     3'b100, 64'hFFFFFFF9, 64'd2,        64'hFFFFFFFD, 34);
        run("rem -7/2",     3'b110, 64'hFFFFFFF9, 64'd2,        64'hFFFFFFFF, 34);
        run("div0",         3'b100, 64'h1234,     64'd0,        64'hFFFFFFFF, 1);
        run("divu0",        3'b101, 64'h1234,     64'd0,        64'hFFFFFFFF, 1);
        run("rem0",         3'b110, 64'h1234,     64'd0,        64'h00001234, 1);
        run("remu0",        3'b111, 64'h1234,     64'd0,        64'h00001234, 1);
        run("div ovf",      3'b100, 64'h80000000, 64'hFFFFFFFF, 64'h80000000, 1);
        run("rem ovf",      3'b110, 64'h80000000, 64'hFFFFFFFF, 64'h00000000, 1);
        run("divu 100/7",   3'b101, 64'd100,      64'd7,        64'd14, 34);
        run("remu 100/7",   3'b111, 64'd100,      64'd7,        64'd2,  34);

        // Flush in cycle 10 of a DIVU
        @(negedge clk);
        drive(1'b1, 3'b101, 64'd1000, 64'd3);
        for (int n = 1; n <= 10; n++) begin
            @(posedge clk); #1;
            if (n == 1) set_start(1'b0);
        end
        check("flush busy before", 64'(m32.busy), 64'd1);
        set_flush(1'b1);
        @(posedge clk); #1;
        set_flush(1'b0);
        check("flush busy cycle 11", 64'(m32.busy), 64'd0);
        check("flush done cycle 11", 64'(m32.done), 64'd0);
        seen = 1'b0;
        repeat (40) begin
            @(posedge clk); #1;
            if (m32.done) seen = 1'b1;
        end
        check("flush no done", 64'(seen), 64'd0);
        check("flush result kept", get_result(), exp_last);

        // Start together with flush is ignored (fast-path and normal op)
        @(negedge clk);
        drive(1'b1, 3'b100, 64'h1234, 64'd0);
        set_flush(1'b1);
        @(posedge clk); #1;
        check("start+flush fast done", 64'(m32.done), 64'd0);
        drive(1'b1, 3'b000, 64'd7, 64'd6);
        @(posedge clk); #1;
        set_start(1'b0);
        set_flush(1'b0);
        check("start+flush busy", 64'(m32.busy), 64'd0);
        check("start+flush result", get_result(), exp_last);

        // Start pulse while busy must not disturb the operation in flight
        @(negedge clk);
        issue(3'b000, 64'd7, 64'd6, 64'd42);
        wait_done("mul poke", 34, 5);

        // Back-to-back: second start in the done cycle of the first
        @(negedge clk);
        issue(3'b000, 64'd11, 64'd13, 64'd143);
        wait_done("b2b first", 34, 0);
        issue(3'b000, 64'd3, 64'd5, 64'd15);
        wait_done("b2b second", 34, 0);

        // Asynchronous reset mid-CALC
        @(negedge clk);
        drive(1'b1, 3'b000, 64'd7, 64'd6);
        for (int n = 1; n <= 5; n++) begin
            @(posedge clk); #1;
            if (n == 1) set_start(1'b0);
        end
        rst32 = 1'b0;
        #1;
        check("rst mid busy", 64'(m32.busy), 64'd0);
        check("rst mid result", 64'(m32.result), 64'd0);
        check("rst mid done", 64'(m32.done), 64'd0);
        @(negedge clk);
        rst32 = 1'b1;
        run("after rst mulhu", 3'b011, 64'hFFFFFFFF, 64'hFFFFFFFF, 64'hFFFFFFFE, 34);

        // XLEN=16 instance
        w16 = 1'b1;
        check("x16 reset result", get_result(), 64'd0);
        run("x16 mulhu",   3'b011, 64'hFFFF, 64'hFFFF, 64'hFFFE, 18);
        run("x16 mul 7x6", 3'b000, 64'd7,    64'd6,    64'd42,   18);
        run("x16 div -7/2",3'b100, 64'hFFF9, 64'd2,    64'hFFFD, 18);
        run("x16 divu0",   3'b101, 64'h55,   64'd0,    64'hFFFF, 1);
        run("x16 div ovf", 3'b100, 64'h8000, 64'hFFFF, 64'h8000, 1);

        $display("%0d/%0d checks passed", pass_cnt, tot_cnt);
        $finish;
    end

endmodule
